date_counter: RTL and testbench

//  BCD calendar register (DD-MM-YYYY) for the Millennium Clock; advances one day per day_tick.

---
 rtl/date_counter.sv | 175 +++++++++++++++++
 tb/tb_date_counter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/date_counter.sv
// BCD DD-MM-YYYY calendar register advancing one day per day_tick, with validated load
// and a one-cycle CHECK state that clamps a loaded day to the month length.
module date_counter #(
    parameter logic [7:0]  RST_DAY   = 8'h01,
    parameter logic [7:0]  RST_MONTH = 8'h01,
    parameter logic [15:0] RST_YEAR  = 16'h2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        day_tick,
    input  logic        load,
    input  logic [7:0]  ld_day,
    input  logic [7:0]  ld_month,
    input  logic [15:0] ld_year,
    input  logic [4:0]  max_days,
    output logic [3:0]  day_unit,
    output logic [3:0]  day_ten,
    output logic [3:0]  month_unit,
    output logic [3:0]  month_ten,
    output logic [3:0]  year_unit,
    output logic [3:0]  year_ten,
    output logic [3:0]  year_hundered,
    output logic [3:0]  year_thousand,
    output logic        load_err,
    output logic        year_wrap,
    output logic        busy
);

    typedef enum logic {RUN, CHECK} state_t;

    state_t          state;
    logic [1:0][3:0] day_r, mon_r;
    logic [3:0][3:0] yr_r;
    logic            pending;

    logic [4:0]      day_bin;
    logic [1:0][3:0] day_inc, mon_inc, md_bcd;
    logic [3:0][3:0] yr_inc;
    logic            yr_carry;
    logic            ld_valid;
    logic [1:0][3:0] ld_d, ld_m;
    logic [3:0][3:0] ld_y;

    assign ld_d = ld_day;
    assign ld_m = ld_month;
    assign ld_y = ld_year;

    assign day_bin = 5'(day_r[1]) * 5'd10 + 5'(day_r[0]);

    always_comb begin
        ld_valid = 1'b1;
        for (int i = 0; i < 2; i++)
            if (ld_d[i] > 4'd9 || ld_m[i] > 4'd9) ld_valid = 1'b0;
        for (int i = 0; i < 4; i++)
            if (ld_y[i] > 4'd9) ld_valid = 1'b0;
        if (!((ld_m[1] == 4'd0 && ld_m[0] != 4'd0) || (ld_m[1] == 4'd1 && ld_m[0] <= 4'd2)))
            ld_valid = 1'b0;
        if (ld_d[1] > 4'd3 || (ld_d[1] == 4'd0 && ld_d[0] == 4'd0) || (ld_d[1] == 4'd3 && ld_d[0] > 4'd1))
            ld_valid = 1'b0;
    end

    always_comb begin
        day_inc = day_r;
        if (day_r[0] == 4'd9) begin
            day_inc[1] = day_r[1] + 4'd1;
            day_inc[0] = 4'd0;
        end else begin
            day_inc[0] = day_r[0] + 4'd1;
        end
        mon_inc = mon_r;
        if (mon_r[0] == 4'd9) begin
            mon_inc[1] = mon_r[1] + 4'd1;
            mon_inc[0] = 4'd0;
        end else begin
            mon_inc[0] = mon_r[0] + 4'd1;
        end
    end

    // Year ripple: carry leaves the top digit only when the year was 9999.
    always_comb begin
        yr_inc   = yr_r;
        yr_carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (yr_carry) begin
                if (yr_r[i] == 4'd9) begin
                    yr_inc[i] = 4'd0;
                end else begin
                    yr_inc[i] = yr_r[i] + 4'd1;
                    yr_carry  = 1'b0;
                end
            end
        end
    end

    always_comb begin
        if (max_days >= 5'd30) begin
            md_bcd[1] = 4'd3;
            md_bcd[0] = 4'(max_days - 5'd30);
        end else if (max_days >= 5'd20) begin
            md_bcd[1] = 4'd2;
            md_bcd[0] = 4'(max_days - 5'd20);
        end else if (max_days >= 5'd10) begin
            md_bcd[1] = 4'd1;
            md_bcd[0] = 4'(max_days - 5'd10);
        end else begin
            md_bcd[1] = 4'd0;
            md_bcd[0] = 4'(max_days);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            day_r     <= RST_DAY;
            mon_r     <= RST_MONTH;
            yr_r      <= RST_YEAR;
            pending   <= 1'b0;
            load_err  <= 1'b0;
            year_wrap <= 1'b0;
            busy      <= 1'b0;
        end else begin
            load_err  <= 1'b0;
            year_wrap <= 1'b0;
            case (state)
                RUN: begin
                    busy <= 1'b0;
                    if (load) begin
                        // Load wins over any tick, including a pending one.
                        pending <= 1'b0;
                        if (ld_valid) begin
                            day_r <= ld_d;
                            mon_r <= ld_m;
                            yr_r  <= ld_y;
                            state <= CHECK;
                            busy  <= 1'b1;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end else if (day_tick || pending) begin
                        pending <= 1'b0;
                        if (day_bin < max_days) begin
                            day_r <= day_inc;
                        end else begin
                            day_r <= 8'h01;
                            if (mon_r == 8'h12) begin
                                mon_r     <= 8'h01;
                                yr_r      <= yr_inc;
                                year_wrap <= yr_carry;
                            end else begin
                                mon_r <= mon_inc;
                            end
                        end
                    end
                end
                CHECK: begin
                    state <= RUN;
                    busy  <= 1'b0;
                    if (day_bin > max_days) day_r <= md_bcd;
                    if (day_tick) pending <= 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign day_unit      = day_r[0];
    assign day_ten       = day_r[1];
    assign month_unit    = mon_r[0];
    assign month_ten     = mon_r[1];
    assign year_unit     = yr_r[0];
    assign year_ten      = yr_r[1];
    assign year_hundered = yr_r[2];
    assign year_thousand = yr_r[3];

endmodule

// File: tb/tb_date_counter.sv
// Bench for date_counter: directed vector table, corner-case sequences and a randomized
// run against an integer calendar model; also plays the day_of_month block for max_days.
module tb_date_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        day_tick = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  ld_day = '0;
    logic [7:0]  ld_month = '0;
    logic [15:0] ld_year = '0;
    logic [4:0]  max_days;
    logic [3:0]  day_unit, day_ten, month_unit, month_ten;
    logic [3:0]  year_unit, year_ten, year_hundered, year_thousand;
    logic        load_err, year_wrap, busy;

    int checks = 0;
    int errors = 0;

    date_counter dut (
        .clk(clk), .rst_n(rst_n), .day_tick(day_tick), .load(load),
        .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year), .max_days(max_days),
        .day_unit(day_unit), .day_ten(day_ten), .month_unit(month_unit), .month_ten(month_ten),
        .year_unit(year_unit), .year_ten(year_ten), .year_hundered(year_hundered),
        .year_thousand(year_thousand), .load_err(load_err), .year_wrap(year_wrap), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int dim(int m, int y);
        bit leap;
        leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        case (m)
            2: return leap ? 29 : 28;
            4, 6, 9, 11: return 30;
            default: return 31;
        endcase
    endfunction

    // Environment: month length for whatever the DUT currently shows.
    always_comb max_days = 5'(dim(int'(month_ten) * 10 + int'(month_unit),
        int'(year_thousand) * 1000 + int'(year_hundered) * 100 + int'(year_ten) * 10 + int'(year_unit)));

    function automatic int dut_date();
        return (int'(day_ten) * 10 + int'(day_unit)) * 1000000
             + (int'(month_ten) * 10 + int'(month_unit)) * 10000
             + int'(year_thousand) * 1000 + int'(year_hundered) * 100 + int'(year_ten) * 10 + int'(year_unit);
    endfunction

    function automatic int pack(int d, int m, int y);
        return d * 1000000 + m * 10000 + y;
    endfunction

    function automatic logic [7:0] bcd2(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] bcd4(int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_raw(logic [7:0] d, logic [7:0] m, logic [15:0] y);
        ld_day = d; ld_month = m; ld_year = y; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_load(int d, int m, int y);
        load_raw(bcd2(d), bcd2(m), bcd4(y));
        chk("busy_in_check", int'(busy), 1);
        step();
        chk("busy_after_check", int'(busy), 0);
    endtask

    task automatic tick();
        day_tick = 1'b1;
        step();
        day_tick = 1'b0;
    endtask

    typedef struct {
        int d, m, y, nt;
        int ed, em, ey;
        int wrap;
    } vec_t;

    vec_t vecs[13];

    // Model state for the random run.
    int md, mm, my, mwrap;

    task automatic model_tick();
        mwrap = 0;
        if (md < dim(mm, my)) md++;
        else begin
            md = 1;
            if (mm == 12) begin
                mm = 1;
                if (my == 9999) begin my = 0; mwrap = 1; end
                else my++;
            end else mm++;
        end
    endtask

    initial begin
        vecs[0]  = '{28, 2, 2023, 1,  1, 3, 2023, 0};
        vecs[1]  = '{28, 2, 2024, 1, 29, 2, 2024, 0};
        vecs[2]  = '{28, 2, 2024, 2,  1, 3, 2024, 0};
        vecs[3]  = '{28, 2, 1900, 1,  1, 3, 1900, 0};
        vecs[4]  = '{28, 2, 2000, 1, 29, 2, 2000, 0};
        vecs[5]  = '{31, 12, 9999, 1, 1, 1,    0, 1};
        vecs[6]  = '{31, 12, 1999, 1, 1, 1, 2000, 0};
        vecs[7]  = '{31, 4, 2021, 0, 30, 4, 2021, 0};
        vecs[8]  = '{31, 1, 2021, 1,  1, 2, 2021, 0};
        vecs[9]  = '{ 9, 9, 2009, 1, 10, 9, 2009, 0};
        vecs[10] = '{29, 2, 2100, 0, 28, 2, 2100, 0};
        vecs[11] = '{31, 2, 2024, 0, 29, 2, 2024, 0};
        vecs[12] = '{31, 12, 1099, 1, 1, 1, 1100, 0};

        // Reset, including a tick while reset is held.
        step();
        chk("reset_date", dut_date(), pack(1, 1, 2000));
        chk("reset_flags", int'({load_err, year_wrap, busy}), 0);
        tick();
        chk("tick_in_reset", dut_date(), pack(1, 1, 2000));
        rst_n = 1'b1;
        step();
        tick();
        chk("first_tick", dut_date(), pack(2, 1, 2000));

        foreach (vecs[i]) begin
            do_load(vecs[i].d, vecs[i].m, vecs[i].y);
            for (int t = 0; t < vecs[i].nt; t++) tick();
            chk($sformatf("vec%0d_date", i), dut_date(), pack(vecs[i].ed, vecs[i].em, vecs[i].ey));
            chk($sformatf("vec%0d_wrap", i), int'(year_wrap), vecs[i].wrap);
            step();
            chk($sformatf("vec%0d_wrap_clr", i), int'(year_wrap), 0);
        end

        // Rejected loads leave the date alone and pulse load_err.
        do_load(15, 7, 2021);
        load_raw(8'h1A, 8'h01, 16'h2021);
        chk("bad_nibble_err", int'(load_err), 1);
        chk("bad_nibble_busy", int'(busy), 0);
        chk("bad_nibble_date", dut_date(), pack(15, 7, 2021));
        step();
        chk("err_pulse_clr", int'(load_err), 0);
        load_raw(8'h10, 8'h13, 16'h2021);
        chk("month13_err", int'(load_err), 1);
        load_raw(8'h00, 8'h05, 16'h2021);
        chk("day00_err", int'(load_err), 1);
        chk("day00_date", dut_date(), pack(15, 7, 2021));

        // Load coincident with a tick: tick discarded.
        day_tick = 1'b1;
        load_raw(bcd2(15), bcd2(6), bcd4(2022));
        day_tick = 1'b0;
        step();
        step();
        chk("load_beats_tick", dut_date(), pack(15, 6, 2022));

        // Tick during CHECK is applied after the clamp.
        load_raw(bcd2(31), bcd2(4), bcd4(2021));
        tick();
        chk("check_clamp", dut_date(), pack(30, 4, 2021));
        step();
        chk("pending_applied", dut_date(), pack(1, 5, 2021));
        step();
        chk("pending_once", dut_date(), pack(1, 5, 2021));

        // Load during CHECK is ignored without error.
        load_raw(bcd2(10), bcd2(10), bcd4(2010));
        load_raw(bcd2(5), bcd2(5), bcd4(2005));
        chk("load_in_check_err", int'(load_err), 0);
        chk("load_in_check_date", dut_date(), pack(10, 10, 2010));

        // Async reset in the middle of CHECK.
        load_raw(bcd2(31), bcd2(6), bcd4(2015));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_date", dut_date(), pack(1, 1, 2000));
        chk("async_rst_busy", int'(busy), 0);
        step();
        rst_n = 1'b1;
        step();

        // Randomized run against the integer model.
        md = 1; mm = 1; my = 2000;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                int d, m, y;
                bit corrupt, valid;
                logic [7:0] db;
                d = $urandom_range(0, 35);
                m = $urandom_range(0, 14);
                y = ($urandom_range(0, 3) == 0) ? $urandom_range(9995, 9999) : $urandom_range(0, 9999);
                if ($urandom_range(0, 2) == 0) begin d = 31; m = 12; end
                corrupt = ($urandom_range(0, 9) == 0);
                db = bcd2(d);
                if (corrupt) db[3:0] = 4'(10 + $urandom_range(0, 5));
                valid = !corrupt && d >= 1 && d <= 31 && m >= 1 && m <= 12;
                load_raw(db, bcd2(m), bcd4(y));
                chk("rnd_load_err", int'(load_err), valid ? 0 : 1);
                if (valid) begin
                    step();
                    md = (d > dim(m, y)) ? dim(m, y) : d;
                    mm = m; my = y;
                end
                chk("rnd_load_date", dut_date(), pack(md, mm, my));
            end else begin
                tick();
                model_tick();
                chk("rnd_tick_date", dut_date(), pack(md, mm, my));
                chk("rnd_tick_wrap", int'(year_wrap), mwrap);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
